// File: rtl/trng_uart_pkg.sv
// Shared types and constants for the TRNG output-FIFO to UART drain path.
// The header byte constant is only used when DRAIN_SYNC_HDR_EN is defined.
package trng_uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LATCH = 2'd1,
        SEND  = 2'd2,
        HDR   = 2'd3
    } drain_state_t;

    localparam logic [7:0] SYNC_HDR_BYTE  = 8'hA5;
    localparam int         PKG_WORD_W     = 32;
    localparam int         BYTES_PER_WORD = PKG_WORD_W / 8;

    // Byte-index counter width; a single-byte word still needs one bit.
    function automatic int idx_width(input int nbytes);
        return (nbytes > 1) ? $clog2(nbytes) : 1;
    endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Multi-flop synchroniser for an asynchronous push-button plus a
// one-cycle rising-edge pulse on the synchronised level.
module btn_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn,
    output logic o_rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            // Oldest sample sits in the MSB; the cast drops the one shifted out.
            r_sync <= SYNC_STAGES'({r_sync, i_btn});
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_rise = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/trng_uart_drain_ctrl.sv
// Drains 32-bit words from the TRNG output FIFO into a byte-wide UART TX,
// LSB first, in streaming or one-word-per-button mode. Optional 0xA5 sync
// header per word when DRAIN_SYNC_HDR_EN is defined.
module trng_uart_drain_ctrl
    import trng_uart_pkg::*;
#(
    parameter int WORD_W      = BYTES_PER_WORD * 8,
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_stream_en,
    input  logic              i_button,
    input  logic              i_fifo_empty,
    output logic              o_fifo_rd_en,
    input  logic [WORD_W-1:0] i_fifo_rd_data,
    output logic              o_tx_valid,
    output logic [7:0]        o_tx_data,
    input  logic              i_tx_ready,
    output logic              o_busy,
    output logic [CNT_W-1:0]  o_word_count
);

    localparam int NB   = WORD_W / 8;
    localparam int IDXW = idx_width(NB);

    drain_state_t      r_state, w_state_nxt;
    logic [WORD_W-1:0] r_shreg;
    logic [IDXW-1:0]   r_byte_idx;
    logic [CNT_W-1:0]  r_word_count;
    logic              r_pending;

    logic              w_btn_rise;
    logic              w_rd_en;
    logic              w_tx_valid;
    logic [7:0]        w_tx_data;
    logic              w_last;
    logic              w_xfer;

    btn_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_btn (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_btn  (i_button),
        .o_rise (w_btn_rise)
    );

    assign w_last = (r_byte_idx == IDXW'(NB - 1));
    assign w_xfer = w_tx_valid & i_tx_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_rd_en     = 1'b0;
        w_tx_valid  = 1'b0;
        w_tx_data   = 8'h00;
        case (r_state)
            IDLE: begin
                if (!i_fifo_empty && (i_stream_en || r_pending)) begin
                    w_rd_en     = 1'b1;
                    w_state_nxt = LATCH;
                end
            end
`ifdef DRAIN_SYNC_HDR_EN
            LATCH: w_state_nxt = HDR;
            HDR: begin
                w_tx_valid = 1'b1;
                w_tx_data  = SYNC_HDR_BYTE;
                if (i_tx_ready) w_state_nxt = SEND;
            end
`else
            LATCH: w_state_nxt = SEND;
`endif
            SEND: begin
                w_tx_valid = 1'b1;
                w_tx_data  = r_shreg[7:0];
                if (i_tx_ready && w_last) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_shreg      <= '0;
            r_byte_idx   <= '0;
            r_word_count <= '0;
            r_pending    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            // The pop consumes the press; a coincident edge collapses into it.
            if (!i_stream_en) begin
                if (w_rd_en)         r_pending <= 1'b0;
                else if (w_btn_rise) r_pending <= 1'b1;
            end

            if (r_state == LATCH) begin
                r_shreg    <= i_fifo_rd_data;
                r_byte_idx <= '0;
            end else if (r_state == SEND && w_xfer) begin
                if (w_last) begin
                    r_word_count <= r_word_count + CNT_W'(1);
                end else begin
                    r_shreg    <= r_shreg >> 8;
                    r_byte_idx <= r_byte_idx + IDXW'(1);
                end
            end
        end
    end

    // Strobes are masked by reset so a mid-word reset drops tx_valid at once.
    assign o_fifo_rd_en = w_rd_en & ~i_rst;
    assign o_tx_valid   = w_tx_valid & ~i_rst;
    assign o_tx_data    = i_rst ? 8'h00 : w_tx_data;
    assign o_busy       = (r_state != IDLE);
    assign o_word_count = r_word_count;

endmodule

// File: tb/tb_trng_uart_drain_ctrl.sv
// Directed bench for trng_uart_drain_ctrl: FIFO model, UART byte sink and
// hand-computed byte streams. Covers the DRAIN_SYNC_HDR_EN build when defined.
module tb_trng_uart_drain_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stream_en;
    logic        button;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [31:0] fifo_rd_data;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        busy;
    logic [15:0] word_count;

    int n_chk = 0;
    int n_err = 0;

    // FIFO model: data appears the cycle after the pop strobe.
    logic [31:0] mem [0:31];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    int          n_pop  = 0;

    // UART sink.
    logic [7:0]  rx [0:255];
    int          rx_n = 0;

    always #5 clk = ~clk;

    assign fifo_empty = (wr_ptr == rd_ptr);

    trng_uart_drain_ctrl dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_stream_en    (stream_en),
        .i_button       (button),
        .i_fifo_empty   (fifo_empty),
        .o_fifo_rd_en   (fifo_rd_en),
        .i_fifo_rd_data (fifo_rd_data),
        .o_tx_valid     (tx_valid),
        .o_tx_data      (tx_data),
        .i_tx_ready     (tx_ready),
        .o_busy         (busy),
        .o_word_count   (word_count)
    );

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            fifo_rd_data <= mem[rd_ptr[4:0]];
            rd_ptr       <= rd_ptr + 1;
            n_pop        <= n_pop + 1;
        end
        if (tx_valid && tx_ready) begin
            rx[rx_n[7:0]] <= tx_data;
            rx_n          <= rx_n + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] w);
        mem[wr_ptr[4:0]] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic wait_rx(input int target, input int max_cyc, input string tag);
        int n = 0;
        while (rx_n < target && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check(tag, rx_n, target);
    endtask

    task automatic press(input int len);
        button = 1'b1;
        cycles(len);
        button = 1'b0;
    endtask

    task automatic check_word(input string tag, input int base, input logic [31:0] w);
        logic [31:0] wv;
        wv = w;
        for (int i = 0; i < 4; i++)
            check($sformatf("%s_b%0d", tag, i), {24'h0, rx[base + i]}, {24'h0, wv[8*i +: 8]});
    endtask

    initial begin
        int base;
        int pop_base;

        rst       = 1'b1;
        stream_en = 1'b0;
        button    = 1'b0;
        tx_ready  = 1'b1;
        cycles(3);
        check("rst_valid", {31'h0, tx_valid}, 32'd0);
        check("rst_busy",  {31'h0, busy},     32'd0);
        check("rst_wc",    {16'h0, word_count}, 32'd0);
        rst = 1'b0;
        cycles(2);
        check("idle_rd_en", {31'h0, fifo_rd_en}, 32'd0);
        check("idle_pend",  {31'h0, dut.r_pending}, 32'd0);

`ifdef DRAIN_SYNC_HDR_EN
        // Header build: A5 precedes every word.
        push(32'h0000_0001);
        stream_en = 1'b1;
        wait_rx(5, 40, "hdr_cnt");
        check("hdr_b0", {24'h0, rx[0]}, 32'h0000_00A5);
        check_word("hdr", 1, 32'h0000_0001);
        check("hdr_wc", {16'h0, word_count}, 32'd1);
        check("hdr_pops", n_pop, 32'd1);
        check("hdr_busy", {31'h0, busy}, 32'd0);
`else
        // Stream mode, two words back to back.
        pop_base = n_pop;
        push(32'h1234_5678);
        push(32'hDEAD_BEEF);
        stream_en = 1'b1;
        wait_rx(8, 60, "s_cnt");
        check_word("s_w0", 0, 32'h1234_5678);
        check_word("s_w1", 4, 32'hDEAD_BEEF);
        check("s_wc",   {16'h0, word_count}, 32'd2);
        check("s_pops", n_pop - pop_base, 32'd2);
        check("s_busy", {31'h0, busy}, 32'd0);
        stream_en = 1'b0;

        // Button mode: one word per press.
        push(32'h0403_0201);
        push(32'h0807_0605);
        push(32'h0C0B_0A09);
        cycles(6);
        check("b_nopress", rx_n, 32'd8);
        press(5);
        cycles(30);
        check("b1_cnt", rx_n, 32'd12);
        check_word("b1", 8, 32'h0403_0201);
        check("b1_wc", {16'h0, word_count}, 32'd3);
        press(5);
        cycles(30);
        check("b2_cnt", rx_n, 32'd16);
        check_word("b2", 12, 32'h0807_0605);
        check("b2_wc", {16'h0, word_count}, 32'd4);

        // Backpressure on byte 2 of A1B2C3D4 (remaining C word drains first).
        push(32'hA1B2_C3D4);
        stream_en = 1'b1;
        begin
            int n = 0;
            while (!(tx_valid && tx_data == 8'hB2) && n < 60) begin
                @(negedge clk);
                n++;
            end
            check("bp_found", {24'h0, tx_data}, 32'h0000_00B2);
        end
        tx_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_valid", {31'h0, tx_valid}, 32'd1);
            check("bp_data",  {24'h0, tx_data},  32'h0000_00B2);
        end
        tx_ready = 1'b1;
        wait_rx(24, 20, "bp_cnt");
        check_word("bp_c", 16, 32'h0C0B_0A09);
        check_word("bp_w", 20, 32'hA1B2_C3D4);
        check("bp_wc", {16'h0, word_count}, 32'd6);
        stream_en = 1'b0;
        cycles(4);

        // Press while empty, word arrives 20 cycles later.
        pop_base = n_pop;
        press(5);
        cycles(20);
        check("pe_pend",  {31'h0, dut.r_pending}, 32'd1);
        check("pe_nopop", n_pop - pop_base, 32'd0);
        push(32'h55AA_33CC);
        #1;
        check("pe_pop_now", {31'h0, fifo_rd_en}, 32'd1);
        wait_rx(28, 20, "pe_cnt");
        check_word("pe", 24, 32'h55AA_33CC);
        check("pe_pend_clr", {31'h0, dut.r_pending}, 32'd0);
        check("pe_wc", {16'h0, word_count}, 32'd7);

        // Reset after byte 1 of CAFEF00D.
        stream_en = 1'b1;
        push(32'hCAFE_F00D);
        wait_rx(30, 20, "r_pre");
        check("r_b0", {24'h0, rx[28]}, 32'h0000_000D);
        check("r_b1", {24'h0, rx[29]}, 32'h0000_00F0);
        rst = 1'b1;
        #1;
        check("r_valid_now", {31'h0, tx_valid}, 32'd0);
        @(negedge clk);
        check("r_valid", {31'h0, tx_valid}, 32'd0);
        check("r_wc",    {16'h0, word_count}, 32'd0);
        check("r_busy",  {31'h0, busy}, 32'd0);
        check("r_nobyte", rx_n, 32'd30);
        rst = 1'b0;
        push(32'h8765_4321);
        wait_rx(34, 30, "r_post_cnt");
        check_word("r_post", 30, 32'h8765_4321);
        check("r_post_wc", {16'h0, word_count}, 32'd1);
        stream_en = 1'b0;
`endif

        cycles(5);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
